perf_counter_sequencer: RTL and testbench
=========================================

PERF_COUNTER_SEQUENCER -- requirements
Module: perf_counter_sequencer

Interface
REQ-001 Parameter: FIFO_DEPTH, default 16, snapshot FIFO depth in 32-bit words, power of 2, minimum 16.
REQ-002 Port: clk  in  1  single clock for all logic.
REQ-003 Port: reset_n  in  1  asynchronous active-low reset.
REQ-004 Port: s_address  in  3  CPU slave word address.
REQ-005 Port: s_read / s_write  in  1 each  CPU slave strobes, one cycle each, never both.
REQ-006 Port: s_writedata  in  32  CPU write data.
REQ-007 Port: s_readdata  out  32  CPU read data, registered, valid the cycle after s_read.
REQ-008 Port: pc_address  out  4  performance-counter word address.
REQ-009 Port: pc_write / pc_begintransfer  out  1 each  performance-counter strobes.
REQ-010 Port: pc_writedata  out  32  performance-counter write data.
REQ-011 Port: pc_readdata  in  32  performance-counter read data; registered by the counter, valid one cycle after the address is driven.

Function
REQ-012 Slave map SHALL be: 0 CTRL (bit0 enable, bits7:4 section mask); 1 INTERVAL (32-bit); 2 STATUS (read-only except W1C); 3 FIFO_DATA (read pops); 4 SAMPLE_COUNT (read-only).
REQ-013 Mask bit4 SHALL read back as 1; section 0 is always run because it gates the counter's global enable.
REQ-014 STATUS SHALL be: bit0 busy (state != IDLE), bit1 overflow (sticky, write 1 to clear), bits[15:8] FIFO level.
REQ-015 INTERVAL values below 16 SHALL be stored as 16.
REQ-016 FSM states SHALL be IDLE, CLEAR, GO, WAIT, RD_ISSUE, RD_CAPTURE, STOP.
REQ-017 IDLE->CLEAR on a 0->1 change of CTRL.enable. CLEAR SHALL issue one write: address 0, data 1. This is a global reset.
REQ-018 GO SHALL issue one write to address 4k+1 for each masked section k, in ascending order, one per cycle. It then loads the interval counter and enters WAIT.
REQ-019 Every counter write SHALL assert pc_write and pc_begintransfer for exactly one cycle.
REQ-020 WAIT SHALL decrement the interval counter each cycle. At 0 it goes to RD_ISSUE if the free FIFO space is at least 3 x popcount(mask). Otherwise it reloads, sets overflow and does not sample.
REQ-021 For each masked section, RD_ISSUE/RD_CAPTURE SHALL read addresses 4k, 4k+1 and 4k+2 in that order: time_lo, time_hi, event.
- Each word takes 2 cycles: drive the address with pc_begintransfer=1 and pc_write=0, then capture pc_readdata and push it to the FIFO.
REQ-022 After the last word, SAMPLE_COUNT SHALL increment (wrapping at 2^32), the interval reloads, and the FSM returns to WAIT.
REQ-023 Clearing CTRL.enable SHALL take effect at the next WAIT or at the end of the current snapshot; a snapshot in progress is never truncated.
- The FSM then enters STOP.
- STOP writes data 0 to address 4k for each masked section, in descending order, then goes to IDLE.
REQ-024 A CTRL or INTERVAL write while busy SHALL update the register, but the mask in use is the one latched at CLEAR.
REQ-025 A FIFO_DATA read when empty SHALL return 0 and SHALL NOT pop.
- A read that pops in the same cycle as a push SHALL leave the level unchanged.
REQ-026 Unmapped slave addresses SHALL read 0, and writes to them SHALL be ignored.

Reset
REQ-027 On reset_n low, all of the following SHALL be 0: the FSM (IDLE), CTRL, SAMPLE_COUNT, overflow, FIFO level and pointers, s_readdata, pc_write, pc_begintransfer, pc_address and pc_writedata.
REQ-028 On reset_n low, INTERVAL SHALL reset to 16.
REQ-029 A reset mid-operation SHALL abort immediately and SHALL NOT issue any stop writes.

Structure
REQ-030 A shared package SHALL hold: the FSM state enum, slave address constants, the counter address stride (4) and offsets (0/1/2), CLEAR data 1, and INTERVAL_MIN 16.
REQ-031 One sub-module, perf_snap_fifo, SHALL hold the synchronous FIFO with FIFO_DEPTH x 32 storage, level output, and simultaneous push/pop.

Verification
REQ-032 Mask 0x1, interval 16, enable -> pc writes are exactly (0,1), (1,0). After 16 cycles, reads of addresses 0, 1 and 2 push 3 words and SAMPLE_COUNT becomes 1.
REQ-033 Mask 0xF -> GO writes go to addresses 1, 5, 9, 13 in consecutive cycles, and each sample pushes 12 words in address order 0,1,2,4,...,14.
REQ-034 Mask 0xF with no CPU reads -> the second sample is skipped, overflow becomes 1 and FIFO level stays 12. Writing STATUS 0x2 clears overflow.
REQ-035 Disable during RD_CAPTURE of word 5 -> all 12 words are pushed, then STOP writes go to addresses 12, 8, 4, 0 with data 0, then busy becomes 0.
REQ-036 INTERVAL write of 3 reads back as 16. FIFO_DATA read when empty returns 0 and level stays 0.
REQ-037 reset_n pulsed low in WAIT -> all outputs are 0 within the same cycle, no pc_write follows, and STATUS reads 0.

Source files
------------

// File: rtl/perf_counter_sequencer_pkg.sv
// Shared types and constants for the performance-counter snapshot sequencer:
// FSM states, CPU slave map, counter address layout and section-walk helpers.
package perf_counter_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CLEAR      = 3'd1,
        ST_GO         = 3'd2,
        ST_WAIT       = 3'd3,
        ST_RD_ISSUE   = 3'd4,
        ST_RD_CAPTURE = 3'd5,
        ST_STOP       = 3'd6
    } seq_state_e;

    localparam logic [2:0] ADDR_CTRL         = 3'd0;
    localparam logic [2:0] ADDR_INTERVAL     = 3'd1;
    localparam logic [2:0] ADDR_STATUS       = 3'd2;
    localparam logic [2:0] ADDR_FIFO_DATA    = 3'd3;
    localparam logic [2:0] ADDR_SAMPLE_COUNT = 3'd4;

    localparam int PC_STRIDE      = 4;
    localparam int PC_OFF_TIME_LO = 0;
    localparam int PC_OFF_TIME_HI = 1;
    localparam int PC_OFF_EVENT   = 2;
    localparam int PC_OFF_END     = PC_OFF_TIME_LO;
    localparam int PC_OFF_BEGIN   = PC_OFF_TIME_HI;

    localparam logic [31:0] PC_CLEAR_DATA = 32'd1;
    localparam logic [31:0] INTERVAL_MIN  = 32'd16;

    function automatic logic [3:0] pc_word_addr(input logic [1:0] sec, input int off);
        return 4'(int'(sec) * PC_STRIDE + off);
    endfunction

    // {found, index} of the lowest masked section above cur
    function automatic logic [2:0] sec_next_up(input logic [3:0] mask, input logic [1:0] cur);
        logic [2:0] r;
        r = '0;
        for (int i = 3; i >= 0; i--) begin
            if (i > int'(cur) && mask[i]) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    // {found, index} of the highest masked section below cur
    function automatic logic [2:0] sec_next_down(input logic [3:0] mask, input logic [1:0] cur);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < int'(cur) && mask[i]) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    function automatic logic [1:0] sec_highest(input logic [3:0] mask);
        logic [1:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) r = 2'(i);
        end
        return r;
    endfunction

    // FIFO words produced by one snapshot: three per masked section
    function automatic logic [3:0] snap_words(input logic [3:0] mask);
        logic [3:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) w = w + 4'd3;
        end
        return w;
    endfunction

endpackage

// File: rtl/perf_snap_fifo.sv
// Synchronous snapshot FIFO: DEPTH x 32 storage, level output, push and pop
// may occur in the same cycle (level then unchanged).
module perf_snap_fifo #(
    parameter int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LVL_W = AW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [31:0]      push_data,
    input  logic             pop,
    output logic [31:0]      pop_data,
    output logic [LVL_W-1:0] level,
    output logic             empty,
    output logic             full
);

    logic [31:0]      mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty    = (level_q == '0);
    assign full     = (level_q == LVL_W'(DEPTH));
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign level    = level_q;
    assign pop_data = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop_ok)      level_d = level_q + 1'b1;
        else if (!push_ok && pop_ok) level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/perf_counter_sequencer.sv
// Drives a section-based performance counter: clears and starts the masked
// sections, periodically snapshots them into a FIFO, and stops them on disable.
module perf_counter_sequencer
    import perf_counter_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  s_address,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic [3:0]  pc_address,
    output logic        pc_write,
    output logic        pc_begintransfer,
    output logic [31:0] pc_writedata,
    input  logic [31:0] pc_readdata
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    seq_state_e  state_q, state_d;
    logic        ctrl_enable_q, ctrl_enable_d;
    logic [2:0]  ctrl_mask_hi_q, ctrl_mask_hi_d;
    logic        start_pending_q, start_pending_d;
    logic [31:0] interval_q, interval_d;
    logic        overflow_q, overflow_d;
    logic [31:0] sample_count_q, sample_count_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  run_mask_q, run_mask_d;
    logic [1:0]  sec_q, sec_d;
    logic [1:0]  word_q, word_d;
    logic [31:0] s_readdata_q, s_readdata_d;
    logic        pc_write_q, pc_write_d;
    logic        pc_bt_q, pc_bt_d;
    logic [3:0]  pc_address_q, pc_address_d;
    logic [31:0] pc_writedata_q, pc_writedata_d;

    logic             fifo_push;
    logic             fifo_pop;
    logic [31:0]      fifo_rdata;
    logic [LVL_W-1:0] fifo_level;
    logic             fifo_empty;
    logic             fifo_full;
    logic [LVL_W-1:0] fifo_free;
    logic [LVL_W-1:0] snap_need;
    logic [3:0]       ctrl_mask;
    logic [31:0]      reload_val;
    logic             busy;
    logic [2:0]       nxt_sec;

    // Section 0 carries the counter's global enable, so it is always in the mask
    assign ctrl_mask  = {ctrl_mask_hi_q, 1'b1};
    assign reload_val = interval_q - 32'd1;
    assign busy       = (state_q != ST_IDLE);
    assign fifo_free  = LVL_W'(FIFO_DEPTH) - fifo_level;
    assign snap_need  = LVL_W'(snap_words(run_mask_q));
    assign fifo_pop   = s_read && (s_address == ADDR_FIFO_DATA) && !fifo_empty;

    perf_snap_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (pc_readdata),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .level     (fifo_level),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_comb begin
        state_d         = state_q;
        ctrl_enable_d   = ctrl_enable_q;
        ctrl_mask_hi_d  = ctrl_mask_hi_q;
        start_pending_d = start_pending_q;
        interval_d      = interval_q;
        overflow_d      = overflow_q;
        sample_count_d  = sample_count_q;
        cnt_d           = cnt_q;
        run_mask_d      = run_mask_q;
        sec_d           = sec_q;
        word_d          = word_q;
        fifo_push       = 1'b0;
        nxt_sec         = '0;
        s_readdata_d    = '0;
        pc_write_d      = 1'b0;
        pc_bt_d         = 1'b0;
        pc_address_d    = '0;
        pc_writedata_d  = '0;

        if (s_write) begin
            case (s_address)
                ADDR_CTRL: begin
                    ctrl_enable_d  = s_writedata[0];
                    ctrl_mask_hi_d = s_writedata[7:5];
                    if (s_writedata[0] && !ctrl_enable_q) start_pending_d = 1'b1;
                    if (!s_writedata[0])                  start_pending_d = 1'b0;
                end
                ADDR_INTERVAL: interval_d = (s_writedata < INTERVAL_MIN) ? INTERVAL_MIN : s_writedata;
                ADDR_STATUS:   if (s_writedata[1]) overflow_d = 1'b0;
                default: ;
            endcase
        end

        if (s_read) begin
            case (s_address)
                ADDR_CTRL:         s_readdata_d = {24'd0, ctrl_mask, 3'd0, ctrl_enable_q};
                ADDR_INTERVAL:     s_readdata_d = interval_q;
                ADDR_STATUS:       s_readdata_d = {16'd0, 8'(fifo_level), 6'd0, overflow_q, busy};
                ADDR_FIFO_DATA:    s_readdata_d = fifo_empty ? 32'd0 : fifo_rdata;
                ADDR_SAMPLE_COUNT: s_readdata_d = sample_count_q;
                default:           s_readdata_d = '0;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (start_pending_q) begin
                    start_pending_d = 1'b0;
                    run_mask_d      = ctrl_mask;
                    state_d         = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                sec_d   = 2'd0;
                state_d = ST_GO;
            end
            ST_GO: begin
                nxt_sec = sec_next_up(run_mask_q, sec_q);
                if (nxt_sec[2]) begin
                    sec_d = nxt_sec[1:0];
                end else begin
                    cnt_d   = reload_val;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!ctrl_enable_q) begin
                    sec_d   = sec_highest(run_mask_q);
                    state_d = ST_STOP;
                end else if (cnt_q == 32'd0) begin
                    // Only start a snapshot that is guaranteed to fit entirely
                    if (fifo_free >= snap_need) begin
                        sec_d   = 2'd0;
                        word_d  = 2'd0;
                        state_d = ST_RD_ISSUE;
                    end else begin
                        cnt_d      = reload_val;
                        overflow_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_RD_ISSUE: state_d = ST_RD_CAPTURE;
            ST_RD_CAPTURE: begin
                fifo_push = 1'b1;
                if (word_q != 2'd2) begin
                    word_d  = word_q + 2'd1;
                    state_d = ST_RD_ISSUE;
                end else begin
                    nxt_sec = sec_next_up(run_mask_q, sec_q);
                    if (nxt_sec[2]) begin
                        sec_d   = nxt_sec[1:0];
                        word_d  = 2'd0;
                        state_d = ST_RD_ISSUE;
                    end else begin
                        sample_count_d = sample_count_q + 32'd1;
                        cnt_d          = reload_val;
                        if (!ctrl_enable_q) begin
                            sec_d   = sec_highest(run_mask_q);
                            state_d = ST_STOP;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end
            end
            ST_STOP: begin
                nxt_sec = sec_next_down(run_mask_q, sec_q);
                if (nxt_sec[2]) sec_d = nxt_sec[1:0];
                else            state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Counter bus is registered from the next state so it lines up with the FSM
        case (state_d)
            ST_CLEAR: begin
                pc_write_d     = 1'b1;
                pc_bt_d        = 1'b1;
                pc_address_d   = pc_word_addr(2'd0, PC_OFF_END);
                pc_writedata_d = PC_CLEAR_DATA;
            end
            ST_GO: begin
                pc_write_d   = 1'b1;
                pc_bt_d      = 1'b1;
                pc_address_d = pc_word_addr(sec_d, PC_OFF_BEGIN);
            end
            ST_RD_ISSUE: begin
                pc_bt_d      = 1'b1;
                pc_address_d = pc_word_addr(sec_d, PC_OFF_TIME_LO + int'(word_d));
            end
            ST_STOP: begin
                pc_write_d   = 1'b1;
                pc_bt_d      = 1'b1;
                pc_address_d = pc_word_addr(sec_d, PC_OFF_END);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            ctrl_enable_q   <= 1'b0;
            ctrl_mask_hi_q  <= '0;
            start_pending_q <= 1'b0;
            interval_q      <= INTERVAL_MIN;
            overflow_q      <= 1'b0;
            sample_count_q  <= '0;
            cnt_q           <= '0;
            run_mask_q      <= '0;
            sec_q           <= '0;
            word_q          <= '0;
            s_readdata_q    <= '0;
            pc_write_q      <= 1'b0;
            pc_bt_q         <= 1'b0;
            pc_address_q    <= '0;
            pc_writedata_q  <= '0;
        end else begin
            state_q         <= state_d;
            ctrl_enable_q   <= ctrl_enable_d;
            ctrl_mask_hi_q  <= ctrl_mask_hi_d;
            start_pending_q <= start_pending_d;
            interval_q      <= interval_d;
            overflow_q      <= overflow_d;
            sample_count_q  <= sample_count_d;
            cnt_q           <= cnt_d;
            run_mask_q      <= run_mask_d;
            sec_q           <= sec_d;
            word_q          <= word_d;
            s_readdata_q    <= s_readdata_d;
            pc_write_q      <= pc_write_d;
            pc_bt_q         <= pc_bt_d;
            pc_address_q    <= pc_address_d;
            pc_writedata_q  <= pc_writedata_d;
        end
    end

    assign s_readdata       = s_readdata_q;
    assign pc_write         = pc_write_q;
    assign pc_begintransfer = pc_bt_q;
    assign pc_address       = pc_address_q;
    assign pc_writedata     = pc_writedata_q;

endmodule

// File: tb/tb_perf_counter_sequencer.sv
// Directed self-checking bench: a counter model feeds a scoreboard of expected
// FIFO words; counter-bus writes and reads are logged for sequence checks.
module tb_perf_counter_sequencer;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_INTV   = 3'd1;
    localparam logic [2:0] A_STATUS = 3'd2;
    localparam logic [2:0] A_FIFO   = 3'd3;
    localparam logic [2:0] A_SCOUNT = 3'd4;

    typedef struct {
        int          cyc;
        logic [3:0]  addr;
        logic [31:0] data;
    } pc_wr_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  s_address = '0;
    logic        s_read = 1'b0;
    logic        s_write = 1'b0;
    logic [31:0] s_writedata = '0;
    logic [31:0] s_readdata;
    logic [3:0]  pc_address;
    logic        pc_write;
    logic        pc_begintransfer;
    logic [31:0] pc_writedata;
    logic [31:0] pc_readdata = '0;

    int          n_cmp = 0;
    int          n_mis = 0;
    int          cyc = 0;
    logic [7:0]  rd_idx = '0;
    logic [31:0] exp_q[$];
    pc_wr_t      wr_log[$];
    logic [3:0]  rd_log[$];

    perf_counter_sequencer #(.FIFO_DEPTH(16)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .s_address        (s_address),
        .s_read           (s_read),
        .s_write          (s_write),
        .s_writedata      (s_writedata),
        .s_readdata       (s_readdata),
        .pc_address       (pc_address),
        .pc_write         (pc_write),
        .pc_begintransfer (pc_begintransfer),
        .pc_writedata     (pc_writedata),
        .pc_readdata      (pc_readdata)
    );

    always #5 clk = ~clk;

    // Counter model: registered read data tagged with a running index and address
    always @(posedge clk) begin
        logic [31:0] v;
        if (pc_begintransfer && !pc_write) begin
            v = {8'hA5, rd_idx, 12'h000, pc_address};
            pc_readdata <= v;
            exp_q.push_back(v);
            rd_idx <= rd_idx + 8'd1;
        end
    end

    always @(posedge clk) begin
        if (reset_n) begin
            if (pc_write) wr_log.push_back('{cyc: cyc, addr: pc_address, data: pc_writedata});
            if (pc_begintransfer && !pc_write) rd_log.push_back(pc_address);
        end
        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        s_address = a; s_writedata = d; s_write = 1'b1;
        @(negedge clk);
        s_write = 1'b0;
        $display("cpu wr addr=%0d data=%08h", a, d);
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        s_address = a; s_read = 1'b1;
        @(negedge clk);
        s_read = 1'b0;
        d = s_readdata;
        $display("cpu rd addr=%0d data=%08h", a, d);
    endtask

    task automatic read_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        cpu_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] d;
        logic [31:0] e;
        cpu_read(A_FIFO, d);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'd0;
        check(tag, d, e);
    endtask

    task automatic wait_reads(input string tag, input int n, input int max_cyc);
        int k;
        k = 0;
        while (rd_log.size() < n && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(rd_log.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] st;
        int k;
        st = 32'd1;
        k = 0;
        while (st[0] && k < 100) begin
            cpu_read(A_STATUS, st);
            k++;
        end
        check(tag, {31'd0, st[0]}, 32'd0);
    endtask

    initial begin
        logic [3:0] exp_addr [12];
        logic [3:0] stop_addr [4];
        exp_addr  = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd12, 4'd13, 4'd14};
        stop_addr = '{4'd12, 4'd8, 4'd4, 4'd0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst pc_write", {31'd0, pc_write}, 32'd0);
        check("rst pc_bt", {31'd0, pc_begintransfer}, 32'd0);
        check("rst pc_addr", {28'd0, pc_address}, 32'd0);
        check("rst s_readdata", s_readdata, 32'd0);
        reset_n = 1'b1;
        read_check("rst status", A_STATUS, 32'd0);
        read_check("rst scount", A_SCOUNT, 32'd0);
        read_check("rst interval", A_INTV, 32'd16);

        // Interval floor and empty FIFO read
        cpu_write(A_INTV, 32'd3);
        read_check("intv floor", A_INTV, 32'd16);
        read_check("fifo empty rd", A_FIFO, 32'd0);
        read_check("fifo empty lvl", A_STATUS, 32'd0);
        cpu_write(A_INTV, 32'd40);
        read_check("intv 40", A_INTV, 32'd40);
        cpu_write(A_INTV, 32'd16);

        // Single section run
        wr_log.delete(); rd_log.delete();
        cpu_write(A_CTRL, 32'h11);
        wait_reads("s0 reads arrive", 3, 200);
        check("s0 wr count", 32'(wr_log.size()), 32'd2);
        if (wr_log.size() >= 2) begin
            check("s0 clear addr", {28'd0, wr_log[0].addr}, 32'd0);
            check("s0 clear data", wr_log[0].data, 32'd1);
            check("s0 go addr", {28'd0, wr_log[1].addr}, 32'd1);
            check("s0 go data", wr_log[1].data, 32'd0);
        end
        for (int i = 0; i < 3; i++) check($sformatf("s0 rd addr %0d", i), {28'd0, rd_log[i]}, {28'd0, exp_addr[i]});
        repeat (2) @(negedge clk);
        read_check("s0 scount", A_SCOUNT, 32'd1);
        for (int i = 0; i < 3; i++) pop_check($sformatf("s0 pop %0d", i));
        wr_log.delete();
        cpu_write(A_CTRL, 32'h10);
        wait_idle("s0 idle");
        check("s0 stop count", 32'(wr_log.size()), 32'd1);
        if (wr_log.size() >= 1) begin
            check("s0 stop addr", {28'd0, wr_log[0].addr}, 32'd0);
            check("s0 stop data", wr_log[0].data, 32'd0);
        end

        // All four sections, no CPU reads -> overflow
        wr_log.delete(); rd_log.delete();
        cpu_write(A_CTRL, 32'hF1);
        wait_reads("f reads arrive", 12, 300);
        check("f wr count", 32'(wr_log.size()), 32'd5);
        if (wr_log.size() >= 5) begin
            for (int i = 1; i < 5; i++) begin
                check($sformatf("f go addr %0d", i), {28'd0, wr_log[i].addr}, 32'(4 * (i - 1) + 1));
                if (i > 1) check($sformatf("f go consec %0d", i), 32'(wr_log[i].cyc - wr_log[i-1].cyc), 32'd1);
            end
        end
        for (int i = 0; i < 12; i++) check($sformatf("f rd addr %0d", i), {28'd0, rd_log[i]}, {28'd0, exp_addr[i]});
        repeat (40) @(negedge clk);
        read_check("f ovf status", A_STATUS, 32'h0000_0C03);
        check("f no extra reads", 32'(rd_log.size()), 32'd12);
        cpu_write(A_INTV, 32'd1000);
        repeat (40) @(negedge clk);
        cpu_write(A_STATUS, 32'h2);
        read_check("f ovf cleared", A_STATUS, 32'h0000_0C01);
        for (int i = 0; i < 12; i++) pop_check($sformatf("f pop %0d", i));
        read_check("f drained", A_STATUS, 32'h0000_0001);
        wr_log.delete();
        cpu_write(A_CTRL, 32'hF0);
        wait_idle("f idle");
        check("f stop count", 32'(wr_log.size()), 32'd4);
        if (wr_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("f stop addr %0d", i), {28'd0, wr_log[i].addr}, {28'd0, stop_addr[i]});
                check($sformatf("f stop data %0d", i), wr_log[i].data, 32'd0);
            end
        end

        // Disable in the middle of a snapshot
        cpu_write(A_INTV, 32'd16);
        wr_log.delete(); rd_log.delete();
        cpu_write(A_CTRL, 32'hF1);
        wait_reads("m word5 issued", 6, 300);
        s_address = A_CTRL; s_writedata = 32'hF0; s_write = 1'b1;
        @(negedge clk);
        s_write = 1'b0;
        wait_idle("m idle");
        check("m all reads", 32'(rd_log.size()), 32'd12);
        check("m wr count", 32'(wr_log.size()), 32'd9);
        if (wr_log.size() >= 9) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("m stop addr %0d", i), {28'd0, wr_log[5+i].addr}, {28'd0, stop_addr[i]});
                check($sformatf("m stop data %0d", i), wr_log[5+i].data, 32'd0);
            end
        end
        read_check("m status", A_STATUS, 32'h0000_0C00);
        read_check("m scount", A_SCOUNT, 32'd3);
        for (int i = 0; i < 12; i++) pop_check($sformatf("m pop %0d", i));

        // Reset while waiting
        wr_log.delete(); rd_log.delete();
        cpu_write(A_CTRL, 32'h11);
        begin
            int k;
            k = 0;
            while (wr_log.size() < 2 && k < 50) begin
                @(negedge clk);
                k++;
            end
        end
        check("r go seen", 32'(wr_log.size()), 32'd2);
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("r pc_write", {31'd0, pc_write}, 32'd0);
        check("r pc_bt", {31'd0, pc_begintransfer}, 32'd0);
        check("r pc_addr", {28'd0, pc_address}, 32'd0);
        check("r pc_wdata", pc_writedata, 32'd0);
        check("r s_readdata", s_readdata, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wr_log.delete(); rd_log.delete();
        repeat (40) @(negedge clk);
        check("r no writes", 32'(wr_log.size()), 32'd0);
        check("r no reads", 32'(rd_log.size()), 32'd0);
        read_check("r status", A_STATUS, 32'd0);
        read_check("r scount", A_SCOUNT, 32'd0);
        check("sb empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
